// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//   Single-port frame-buffer arbiter. It sits between the VGA timing generator
//   (pixel reads), the draw engine (posted writes) and a synchronous-read RAM
//   with one cycle of read latency.
//
//   Per-cycle grant, fixed priority:
//     pixel read  >  write-FIFO drain  >  clear-sweep write
//   The winning request is registered onto mem_* at the next clock edge.
//   Writes are posted into a small FIFO and drained into cycles the pixel path
//   leaves idle. The clear sequencer first waits for the FIFO to empty and then
//   sweeps CLEAR_COLOR across FB_WORDS words.
//
//   Optional feature: define FB_STALL_CNT_EN to build the write-stall counter.
//   Without it, stall_cnt is tied to zero.
//
// Ports
//   CLOCK_50     in   1       system clock
//   reset        in   1       asynchronous, active-high reset
//   pix_req      in   1       pixel read request (one per cycle)
//   pix_addr     in   ADDR_W  pixel read address
//   pix_data     out  DATA_W  pixel read data (zero when pix_valid is low)
//   pix_valid    out  1       pix_data valid, two cycles after pix_req
//   wr_req       in   1       write request, taken when wr_req & wr_ready
//   wr_addr      in   ADDR_W  write address
//   wr_data      in   DATA_W  write data
//   wr_ready     out  1       FIFO not full and no clear pending/running
//   clear_start  in   1       one-cycle pulse, starts a clear sweep
//   clear_busy   out  1       clear pending or running
//   clear_done   out  1       pulse on the edge that writes the last clear word
//   mem_addr     out  ADDR_W  RAM address (registered)
//   mem_wdata    out  DATA_W  RAM write data (registered)
//   mem_we       out  1       RAM write enable (registered)
//   mem_rdata    in   DATA_W  RAM read data, one cycle after the address
//   stall_cnt    out  16      saturating count of pixel-blocked write cycles
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
   parameter int                ADDR_W      = 17,
   parameter int                DATA_W      = 8,
   parameter int                FB_WORDS    = 76800,
   parameter int                WBUF_DEPTH  = 8,
   parameter logic [DATA_W-1:0] CLEAR_COLOR = 8'h00
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              pix_req,
   input  logic [ADDR_W-1:0] pix_addr,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       stall_cnt
);

   localparam int PTR_W = $clog2(WBUF_DEPTH);
   // One extra bit so a full FIFO and an empty FIFO have distinct counts.
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WBUF_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FB_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLR_WAIT = 2'd1,
      CLEARING = 2'd2
   } state_t;

   state_t            state;
   state_t            nextState;

   logic [ADDR_W-1:0] wbufAddr [WBUF_DEPTH];
   logic [DATA_W-1:0] wbufData [WBUF_DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [CNT_W-1:0]  fifoCount;
   logic              fifoEmpty;
   logic              fifoFull;
   logic              push;
   logic              pop;

   logic              grantRead;
   logic              grantDrain;
   logic              grantClear;
   logic              lastClear;
   logic [ADDR_W-1:0] clearCnt;

   logic              readVld_p1;
   logic              readVld_p2;

   // Grant decode and FIFO handshake, all from registered state.
   always_comb begin
      fifoEmpty  = (fifoCount == '0);
      fifoFull   = (fifoCount == FULL_CNT);
      grantRead  = pix_req;
      grantDrain = !pix_req && !fifoEmpty;
      grantClear = !pix_req && fifoEmpty && (state == CLEARING);
      lastClear  = grantClear && (clearCnt == LAST_WORD);
      wr_ready   = !fifoFull && (state == IDLE);
      clear_busy = (state != IDLE);
      push       = wr_req && wr_ready;
      pop        = grantDrain;
   end

   // Clear sequencer next state.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:     if (clear_start) nextState = CLR_WAIT;
         CLR_WAIT: if (fifoEmpty)   nextState = CLEARING;
         CLEARING: if (lastClear)   nextState = IDLE;
         default:                   nextState = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Clear counter restarts at 0 every time the sequencer waits for the drain.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         clearCnt   <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= lastClear;
         if (state == CLR_WAIT) begin
            clearCnt <= '0;
         end else if (grantClear) begin
            clearCnt <= clearCnt + ADDR_W'(1);
         end
      end
   end

   // Write FIFO control; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifoCount <= fifoCount + CNT_W'(1);
            2'b01:   fifoCount <= fifoCount - CNT_W'(1);
            default: fifoCount <= fifoCount;
         endcase
      end
   end

   // FIFO storage is data only and needs no reset.
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         wbufAddr[wrPtr] <= wr_addr;
         wbufData[wrPtr] <= wr_data;
      end
   end

   // ---- stage p1: grant registered onto the RAM port ----
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         readVld_p1 <= 1'b0;
      end else begin
         readVld_p1 <= grantRead;
         if (grantRead) begin
            mem_addr <= pix_addr;
            mem_we   <= 1'b0;
         end else if (grantDrain) begin
            mem_addr  <= wbufAddr[rdPtr];
            mem_wdata <= wbufData[rdPtr];
            mem_we    <= 1'b1;
         end else if (grantClear) begin
            mem_addr  <= clearCnt;
            mem_wdata <= CLEAR_COLOR;
            mem_we    <= 1'b1;
         end else begin
            mem_we <= 1'b0;
         end
      end
   end

   // ---- stage p2: RAM output valid, tagged for the pixel path ----
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         readVld_p2 <= 1'b0;
      end else begin
         readVld_p2 <= readVld_p1;
      end
   end

   // The RAM's own output register supplies the data; gating keeps pix_data
   // at zero outside valid cycles (including reset).
   assign pix_valid = readVld_p2;
   assign pix_data  = readVld_p2 ? mem_rdata : '0;

`ifdef FB_STALL_CNT_EN
   function automatic logic [15:0] satInc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic        stallNow;
   logic [15:0] stallCount;

   // A stall is a cycle where write or clear work exists but the pixel read wins.
   assign stallNow = pix_req && (!fifoEmpty || (state == CLEARING));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         stallCount <= '0;
      end else if (clear_start) begin
         stallCount <= '0;
      end else if (stallNow) begin
         stallCount <= satInc(stallCount);
      end
   end

   assign stall_cnt = stallCount;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//   Scoreboard bench for vga_fb_arbiter (FB_WORDS=16). Stimulus pushes the
//   expected pixel reads (data + due cycle) and expected RAM writes (addr +
//   data) into queues; a forked monitor pops and compares whenever pix_valid
//   or mem_we is seen. RAM model is sync-read, preloaded with addr ^ 8'h5A.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

   localparam int AW = 17;
   localparam int DW = 8;

   logic          CLOCK_50 = 1'b0;
   logic          reset;
   logic          pix_req;
   logic [AW-1:0] pix_addr;
   logic [DW-1:0] pix_data;
   logic          pix_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ready;
   logic          clear_start;
   logic          clear_busy;
   logic          clear_done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic [15:0]   stall_cnt;

   int            nChecks = 0;
   int            nFails  = 0;
   int            cyc     = 0;
   logic          preload;
   logic [DW-1:0] ram [256];
   logic [DW-1:0] ramQ;

   typedef struct { logic [DW-1:0] data; int due; } pixExp_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wrExp_t;
   pixExp_t expPix[$];
   wrExp_t  expWr[$];

   vga_fb_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .FB_WORDS(16), .WBUF_DEPTH(8), .CLEAR_COLOR(8'h00)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .pix_req(pix_req), .pix_addr(pix_addr), .pix_data(pix_data), .pix_valid(pix_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .stall_cnt(stall_cnt)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   always @(posedge CLOCK_50) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      end else if (mem_we) begin
         ram[mem_addr[7:0]] <= mem_wdata;
      end
      ramQ <= ram[mem_addr[7:0]];
   end
   assign mem_rdata = ramQ;

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nChecks++;
      if (act !== req) begin
         nFails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic issueRead(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pix_req  = 1'b1;
      pix_addr = a;
      expPix.push_back('{data: d, due: cyc + 2});
   endtask

   task automatic issueWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      expWr.push_back('{addr: a, data: d});
   endtask

   task automatic checkResetState(input string pfx);
      check({pfx, "_pix_data"},   pix_data,   0);
      check({pfx, "_pix_valid"},  pix_valid,  0);
      check({pfx, "_mem_addr"},   mem_addr,   0);
      check({pfx, "_mem_wdata"},  mem_wdata,  0);
      check({pfx, "_mem_we"},     mem_we,     0);
      check({pfx, "_wr_ready"},   wr_ready,   1);
      check({pfx, "_clear_busy"}, clear_busy, 0);
      check({pfx, "_clear_done"}, clear_done, 0);
      check({pfx, "_stall_cnt"},  stall_cnt,  0);
   endtask

   task automatic runMonitor();
      pixExp_t pe;
      wrExp_t  wexp;
      forever begin
         @(negedge CLOCK_50);
         if (!reset) begin
            if (pix_valid) begin
               nChecks++;
               if (expPix.size() == 0) begin
                  nFails++;
                  $display("FAIL pix_unexpected: got data %0h at cycle %0d, expected no read", pix_data, cyc);
               end else begin
                  pe = expPix.pop_front();
                  if (pix_data !== pe.data || cyc != pe.due) begin
                     nFails++;
                     $display("FAIL pix_read: got %0h at cycle %0d, expected %0h at cycle %0d",
                              pix_data, cyc, pe.data, pe.due);
                  end
               end
            end
            if (mem_we) begin
               nChecks++;
               if (expWr.size() == 0) begin
                  nFails++;
                  $display("FAIL mem_write_unexpected: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
               end else begin
                  wexp = expWr.pop_front();
                  if (mem_addr !== wexp.addr || mem_wdata !== wexp.data) begin
                     nFails++;
                     $display("FAIL mem_write: got addr %0h data %0h, expected addr %0h data %0h",
                              mem_addr, mem_wdata, wexp.addr, wexp.data);
                  end
               end
            end
         end
      end
   endtask

   initial begin
      logic [DW-1:0] t2Exp [4];
      bit            got;
      logic          prevBusy;
      int            doneExtra;

      t2Exp = '{8'h5A, 8'h5B, 8'h58, 8'h59};
      preload = 1'b1; reset = 1'b1;
      pix_req = 1'b0; pix_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; clear_start = 1'b0;
      fork runMonitor(); join_none

      step(); step();
      preload = 1'b0;
      checkResetState("init");
      reset = 1'b0;
      step();

      // Reset while clear is pending with three writes queued behind pixel reads.
      for (int i = 0; i < 5; i++) begin
         issueRead(AW'(8'h80 + i), 8'(8'h80 + i) ^ 8'h5A);
         if (i < 3) issueWrite(AW'(8'h40 + i), 8'(8'h11 + i));
         else wr_req = 1'b0;
         clear_start = (i == 3);
         if (i == 4) begin
            check("t1_busy_before_reset", clear_busy, 1);
            check("t1_ready_before_reset", wr_ready, 0);
         end
         step();
      end
      pix_req = 1'b0; clear_start = 1'b0;
      reset = 1'b1;
      expPix.delete();
      expWr.delete();
      #1;
      checkResetState("midclear");
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("t1_no_we_after_reset", mem_we, 0);
      end
      check("t1_ready_after_reset", wr_ready, 1);
      check("t1_busy_after_reset", clear_busy, 0);

      // Read latency: addr 0..3 back to back.
      for (int i = 0; i < 4; i++) begin
         issueRead(AW'(i), t2Exp[i]);
         step();
      end
      pix_req = 1'b0;
      repeat (4) step();
      check("t2_reads_done", expPix.size(), 0);

      // Priority: 8 writes fill the FIFO while pixel reads hold the port 20 cycles.
      for (int i = 0; i < 20; i++) begin
         issueRead(AW'(8'h80 + i), 8'(8'h80 + i) ^ 8'h5A);
         check("t3_no_we_during_reads", mem_we, 0);
         if (i < 8) begin
            check("t3_ready_filling", wr_ready, 1);
            issueWrite(AW'(8'h20 + i), 8'(8'hA0 + i));
         end else begin
            wr_req = 1'b0;
            check("t3_not_ready_full", wr_ready, 0);
         end
         step();
      end
      pix_req = 1'b0;
      check("t3_no_we_last_read", mem_we, 0);
      // FIFO still full this cycle: the held 9th write is not taken yet.
      check("t4_not_ready_at_drain", wr_ready, 0);
      issueWrite(AW'(8'h28), 8'hA8);
      step();
      check("t4_ready_after_pop", wr_ready, 1);
      check("t4_first_drain", mem_we, 1);
      step();
      wr_req = 1'b0;
      // Push and pop in the same cycle kept the FIFO below full.
      check("t4_ready_after_push_pop", wr_ready, 1);
      for (int i = 0; i < 8; i++) begin
         check("t3_drain_consecutive", mem_we, 1);
         step();
      end
      check("t3_drain_end", mem_we, 0);
      check("t3_writes_done", expWr.size(), 0);
`ifdef FB_STALL_CNT_EN
      // The first held read cycle saw an empty FIFO; the other 19 were stalls.
      check("t6_stall_after_t3", stall_cnt, 19);
`else
      check("t6_stall_tied_zero", stall_cnt, 0);
`endif

      // Clear with 2 queued writes; the second write arrives with clear_start.
      issueRead(AW'(8'h94), 8'h94 ^ 8'h5A);
      issueWrite(AW'(8'h30), 8'hC0);
      step();
      issueRead(AW'(8'h95), 8'h95 ^ 8'h5A);
      check("t5_ready_with_start", wr_ready, 1);
      issueWrite(AW'(8'h31), 8'hC1);
      clear_start = 1'b1;
      step();
      wr_req = 1'b0; clear_start = 1'b0;
      check("t5_busy", clear_busy, 1);
      check("t5_not_ready", wr_ready, 0);
      for (int k = 0; k < 16; k++) expWr.push_back('{addr: AW'(k), data: 8'h00});
      got = 1'b0; prevBusy = 1'b1;
      for (int n = 0; n < 200 && !got; n++) begin
         if (clear_done) begin
            got = 1'b1;
            check("t5_busy_falls_with_done", clear_busy, 0);
            check("t5_busy_before_done", prevBusy, 1);
            check("t5_last_we", mem_we, 1);
            check("t5_last_addr", mem_addr, 15);
         end
         prevBusy = clear_busy;
         if (n % 3 == 0) issueRead(AW'(8'h98 + n / 3), 8'(8'h98 + n / 3) ^ 8'h5A);
         else pix_req = 1'b0;
         step();
      end
      check("t5_done_seen", got, 1);
      pix_req = 1'b0;
      doneExtra = 0;
      for (int i = 0; i < 5; i++) begin
         if (clear_done) doneExtra++;
         step();
      end
      check("t5_single_done", doneExtra, 0);
      check("t5_writes_done", expWr.size(), 0);
      for (int i = 0; i < 16; i++) begin
         issueRead(AW'(i), 8'h00);
         step();
      end
      issueRead(AW'(8'h30), 8'hC0);
      step();
      issueRead(AW'(8'h31), 8'hC1);
      step();
      pix_req = 1'b0;
      repeat (4) step();
      check("t5_readback_done", expPix.size(), 0);

`ifdef FB_STALL_CNT_EN
      // Saturation: one queued write stuck behind 70000 pixel reads.
      issueRead(AW'(8'hF0), 8'hF0 ^ 8'h5A);
      issueWrite(AW'(8'h32), 8'hD0);
      step();
      wr_req = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         issueRead(AW'(8'hF0), 8'hF0 ^ 8'h5A);
         step();
      end
      pix_req = 1'b0;
      check("t6_stall_saturated", stall_cnt, 16'hFFFF);
      clear_start = 1'b1;
      for (int k = 0; k < 16; k++) expWr.push_back('{addr: AW'(k), data: 8'h00});
      step();
      clear_start = 1'b0;
      check("t6_stall_cleared", stall_cnt, 0);
      for (int n = 0; n < 200 && clear_busy; n++) step();
      check("t6_clear_finished", clear_busy, 0);
      repeat (3) step();
      check("t6_writes_done", expWr.size(), 0);
`endif

      repeat (5) step();
      check("end_pix_queue_empty", expPix.size(), 0);
      check("end_wr_queue_empty", expWr.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
